aes_req_scheduler: RTL
======================

// Module: aes_req_scheduler
// PURPOSE
//  Round-robin scheduler sharing one AES_128bits core among NUM_REQ requesters.
//  It accepts one request (key + plaintext), issues a one-cycle Valid to the core and waits for Done.
//  It then returns the ciphertext to the granted requester, with a watchdog on core completion.
//  It sits between the requester ports and the single AES core instance.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  TIMEOUT  64  max cycles in WAIT before aborting with rsp_err
// PORTS
//  CLK         in   1            clock, rising edge
//  RST         in   1            reset, synchronous, active-high
//  req_valid   in   NUM_REQ      per-requester request; held until its req_ready pulse
//  req_key     in   NUM_REQ*128  key of requester i at bits [128*i +: 128]
//  req_plain   in   NUM_REQ*128  plaintext of requester i at bits [128*i +: 128]
//  req_ready   out  NUM_REQ      one-hot 1-cycle accept pulse
//  rsp_valid   out  NUM_REQ      one-hot 1-cycle response pulse
//  rsp_data    out  128          ciphertext; valid while any rsp_valid bit is high
//  rsp_err     out  1            high with rsp_valid when the request timed out
//  aes_valid   out  1            to core Valid; 1-cycle pulse
//  aes_key     out  128          to core Key; stable from ISSUE until RESP
//  aes_plain   out  128          to core Plain_txt; stable from ISSUE until RESP
//  aes_done    in   1            from core Done
//  aes_busy    in   1            from core Busy
//  aes_cypher  in   128          from core Cypher_txt; sampled when aes_done=1
// BEHAVIOUR
//  Reset (RST=1 at an edge, any state):
//   - state=IDLE; all outputs 0; timeout counter 0
//   - last_grant=NUM_REQ-1, so requester 0 has first priority
//   - the core is reset separately by the integrator
//  FSM, all outputs registered:
//   IDLE:
//    - if |req_valid and !aes_busy: pick the first set bit searching last_grant+1 upward, with wrap.
//    - latch idx, req_key[idx] and req_plain[idx] into aes_key and aes_plain; go to ISSUE.
//    - otherwise stay in IDLE.
//   ISSUE (1 cycle):
//    - aes_valid=1 and req_ready[idx]=1; clear the counter; go to WAIT.
//   WAIT:
//    - counter increments each cycle.
//    - aes_done=1: capture aes_cypher into rsp_data, set rsp_err=0; go to RESP.
//    - else if counter==TIMEOUT-1: rsp_data=0, rsp_err=1; go to RESP.
//    - aes_done and the timeout limit in the same cycle: done wins, rsp_err=0.
//   RESP (1 cycle):
//    - rsp_valid[idx]=1; last_grant=idx; go to IDLE.
//    - rsp_data and rsp_err are cleared on exit.
//  Latency:
//   - req_valid sampled in IDLE at cycle T: aes_valid/req_ready at T+1.
//   - aes_done at cycle D: rsp_valid at D+1; IDLE at D+2; next aes_valid no earlier than D+3.
//  Request handling:
//   - Only one request is in flight at a time.
//   - req_valid changes after the latch cycle are ignored.
//   - A request dropped before it is selected is never granted.
//  Spurious inputs:
//   - aes_done outside WAIT is ignored.
//   - aes_busy only gates selection in IDLE.
//  Counter width: $clog2(TIMEOUT+1); it never wraps because WAIT exits at TIMEOUT-1.
//  Fairness: a continuously requesting port waits at most NUM_REQ-1 other transactions.
// TESTING
//  1 Single request:
//    - stimulus: req_valid=4'b0001, key=000102..0f, plain=00112233..eeff; core model gives Done after 11 cycles.
//    - required: aes_valid 1 cycle after the request; rsp_valid=0001; rsp_data=69c4e0d8..c55a; rsp_err=0.
//  2 Round robin:
//    - stimulus: req_valid=4'b1111 held throughout.
//    - required: grant order 0,1,2,3,0; each rsp_valid matches its req_ready index.
//  3 Timeout:
//    - stimulus: core never asserts Done.
//    - required: rsp_valid at WAIT entry+64 cycles; rsp_err=1; rsp_data=0; the next request is then served normally.
//  4 Busy gating and spurious done:
//    - stimulus: aes_busy=1 in IDLE with req_valid=0010; aes_done pulsed in IDLE.
//    - required: no grant until aes_busy=0; no rsp_valid from the spurious done.
//  5 Reset mid-WAIT:
//    - stimulus: RST=1 for 1 cycle during WAIT.
//    - required: all outputs 0 next cycle; a late aes_done is ignored; requester 0 is granted first afterwards.
//  6 Done at the limit:
//    - stimulus: aes_done in the same cycle as counter==TIMEOUT-1.
//    - required: rsp_err=0; rsp_data equals aes_cypher.

Source files
------------

// File: rtl/aes_req_scheduler.sv
// Round-robin front end sharing a single AES-128 core among NUM_REQ requesters.
// Serves one request at a time and returns the ciphertext, or an error when the core times out.
module aes_req_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_plain,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [127:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   aes_valid,
  output logic [127:0]           aes_key,
  output logic [127:0]           aes_plain,
  input  logic                   aes_done,
  input  logic                   aes_busy,
  input  logic [127:0]           aes_cypher
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  // Search starts just after the last served port, so a held request waits
  // for at most NUM_REQ-1 other transactions.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would otherwise infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      idx        <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      aes_valid  <= 1'b0;
      aes_key    <= '0;
      aes_plain  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && !aes_busy) begin
            idx       <= pick_idx;
            aes_key   <= req_key[128*pick_idx +: 128];
            aes_plain <= req_plain[128*pick_idx +: 128];
            aes_valid <= 1'b1;
            req_ready <= ONE << pick_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          aes_valid <= 1'b0;
          req_ready <= '0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the last allowed cycle still counts as success.
          if (aes_done) begin
            rsp_data  <= aes_cypher;
            rsp_err   <= 1'b0;
            rsp_valid <= ONE << idx;
            state     <= RESP;
          end else if (cnt == LIMIT) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= ONE << idx;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          rsp_valid  <= '0;
          rsp_data   <= '0;
          rsp_err    <= 1'b0;
          last_grant <= idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
